// File: rtl/move_request_generator.sv
// Push-button to paced one-hot move requests: sync, debounce, buffered turn, per-tick motion FSM.
// Optional macro PENDING_TIMEOUT_EN expires an unconsumed turn after PENDING_TICKS ticks.
module move_request_generator #(
   parameter int TICK_DIV        = 2500000,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int PENDING_TICKS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] btn_raw,
   input  logic [3:0] valid_moves,
   output logic [3:0] move_direction,
   output logic       move_strobe,
   output logic [3:0] cur_dir,
   output logic [3:0] pending_dir
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STOPPED, MOVING} state_t;

   logic [3:0]    sync1, sync2, stable, stable_d;
   logic [DW-1:0] deb_cnt [4];
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    press_vec, press_dir;
   state_t        state_q, state_d;
   logic [3:0]    cur_q, cur_d, move_q, move_d, pend_q, pend_d;
   logic          consumed;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         stable_d <= stable;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Lowest set bit wins, giving RIGHT > UP > DOWN > LEFT on simultaneous presses.
   assign press_vec = stable & ~stable_d;
   assign press_dir = press_vec & (~press_vec + 4'd1);

   always_ff @(posedge clk) begin
      if (rst || !enable) tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TW'(1);
   end

   assign tick = enable && (tick_cnt == TICK_LAST);

`ifdef PENDING_TIMEOUT_EN
   localparam int AW = (PENDING_TICKS > 0) ? $clog2(PENDING_TICKS + 1) : 1;
   logic [AW-1:0] age_q, age_d;

   always_ff @(posedge clk) begin
      if (rst) age_q <= '0;
      else age_q <= age_d;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      move_d   = '0;
      pend_d   = pend_q;
      consumed = 1'b0;
`ifdef PENDING_TIMEOUT_EN
      age_d    = age_q;
`endif
      if (tick) begin
         if ((pend_q & valid_moves) != 4'b0000) begin
            move_d   = pend_q;
            cur_d    = pend_q;
            pend_d   = '0;
            consumed = 1'b1;
            state_d  = MOVING;
         end else if (state_q == MOVING && (cur_q & valid_moves) != 4'b0000) begin
            move_d  = cur_q;
            state_d = MOVING;
         end else begin
            cur_d   = '0;
            state_d = STOPPED;
         end
      end
`ifdef PENDING_TIMEOUT_EN
      if (consumed) begin
         age_d = '0;
      end else if (tick && pend_q != 4'b0000) begin
         if (age_q >= AW'(PENDING_TICKS - 1)) begin
            pend_d = '0;
            age_d  = '0;
         end else begin
            age_d = age_q + AW'(1);
         end
      end
`endif
      // A press arriving with a consuming tick still becomes the new pending turn.
      if (press_dir != 4'b0000) begin
         pend_d = press_dir;
`ifdef PENDING_TIMEOUT_EN
         age_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STOPPED;
         cur_q   <= '0;
         move_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         move_q  <= move_d;
         pend_q  <= pend_d;
      end
   end

   assign move_direction = move_q;
   assign move_strobe    = |move_q;
   assign cur_dir        = cur_q;
   assign pending_dir    = pend_q;

endmodule

// File: tb/tb_move_request_generator.sv
// Bench for move_request_generator: cycle model compared every cycle plus directed literal checks.
module tb_move_request_generator;

   localparam int TD = 8;
   localparam int DB = 4;
   localparam int PT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] btn_raw = 4'b0000;
   logic [3:0] valid_moves = 4'b0000;
   logic [3:0] move_direction;
   logic       move_strobe;
   logic [3:0] cur_dir;
   logic [3:0] pending_dir;

   int checks = 0;
   int errors = 0;

   move_request_generator #(
      .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .PENDING_TICKS(PT)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .btn_raw(btn_raw),
      .valid_moves(valid_moves), .move_direction(move_direction),
      .move_strobe(move_strobe), .cur_dir(cur_dir), .pending_dir(pending_dir)
   );

   always #5 clk = ~clk;

   // Behavioural model: delay line, run-length debounce, phase counter, turn rules.
   logic [3:0] m_sync1, m_sync2, m_level, m_level_prev;
   int         m_run [4];
   int         m_phase, m_age;
   logic [3:0] m_pend, m_cur, m_move;
   bit         model_ready = 1'b0;

   always @(posedge clk) begin : model
      logic [3:0] rise, pick, nxt_pend, nxt_cur, nxt_move, nxt_level;
      bit tick, taken;
      if (rst) begin
         m_sync1 = 0; m_sync2 = 0; m_level = 0; m_level_prev = 0;
         for (int b = 0; b < 4; b++) m_run[b] = 0;
         m_phase = 0; m_age = 0; m_pend = 0; m_cur = 0; m_move = 0;
         model_ready = 1'b1;
      end else begin
         rise = m_level & ~m_level_prev;
         pick = 4'b0000;
         for (int b = 0; b < 4; b++)
            if (rise[b] && pick == 4'b0000) pick = 4'(1 << b);
         tick = enable && (m_phase == TD - 1);
         nxt_pend = m_pend; nxt_cur = m_cur; nxt_move = 4'b0000; taken = 1'b0;
         if (tick) begin
            if ((m_pend & valid_moves) != 4'b0000) begin
               nxt_move = m_pend; nxt_cur = m_pend; nxt_pend = 4'b0000; taken = 1'b1;
            end else if ((m_cur & valid_moves) != 4'b0000) begin
               nxt_move = m_cur;
            end else begin
               nxt_cur = 4'b0000;
            end
         end
`ifdef PENDING_TIMEOUT_EN
         if (taken) m_age = 0;
         else if (tick && m_pend != 4'b0000) begin
            m_age++;
            if (m_age >= PT) begin
               nxt_pend = 4'b0000;
               m_age = 0;
            end
         end
`endif
         if (pick != 4'b0000) begin
            nxt_pend = pick;
            m_age = 0;
         end
         nxt_level = m_level;
         for (int b = 0; b < 4; b++) begin
            if (m_sync2[b] != m_level[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  nxt_level[b] = m_sync2[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_level_prev = m_level;
         m_level = nxt_level;
         m_sync2 = m_sync1;
         m_sync1 = btn_raw;
         m_phase = enable ? (m_phase + 1) % TD : 0;
         m_pend = nxt_pend; m_cur = nxt_cur; m_move = nxt_move;
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ready) begin
         check("move_direction", move_direction, m_move);
         check("move_strobe", {3'b000, move_strobe}, {3'b000, m_move != 4'b0000});
         check("cur_dir", cur_dir, m_cur);
         check("pending_dir", pending_dir, m_pend);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_strobes(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (move_strobe) c++;
      end
   endtask

   task automatic wait_strobe(input int budget, output bit seen, output int waited);
      seen = 1'b0;
      waited = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         waited++;
         if (move_strobe) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin : stim
      int c, waited;
      bit seen;
      step(1);
      check("reset_move", move_direction, 4'b0000);
      check("reset_cur", cur_dir, 4'b0000);
      check("reset_pending", pending_dir, 4'b0000);
      step(2);
      rst = 1'b0;
      enable = 1'b1;
      valid_moves = 4'b1111;

      // Idle: no buttons, no motion.
      count_strobes(40, c);
      check("idle_strobes", 4'(c), 4'd0);
      check("idle_cur", cur_dir, 4'b0000);

      // RIGHT press: pending after sync + debounce latency, then one pulse per tick.
      btn_raw = 4'b0001;
      step(6);
      check("press_latency_early", pending_dir, 4'b0000);
      step(1);
      check("press_pending", pending_dir, 4'b0001);
      wait_strobe(12, seen, waited);
      check("first_move_seen", {3'b000, seen}, 4'b0001);
      check("first_move_dir", move_direction, 4'b0001);
      check("first_move_cur", cur_dir, 4'b0001);
      check("first_move_pend", pending_dir, 4'b0000);
      wait_strobe(12, seen, waited);
      check("pulse_spacing", 4'(waited), 4'd8);
      btn_raw = 4'b0000;
      step(20);

      // Glitch shorter than debounce window.
      btn_raw = 4'b0001;
      step(2);
      btn_raw = 4'b0000;
      step(20);
      check("glitch_pending", pending_dir, 4'b0000);
      check("glitch_cur", cur_dir, 4'b0001);

      // Buffered UP turn waits until the maze allows it.
      valid_moves = 4'b0001;
      btn_raw = 4'b0010;
      step(10);
      btn_raw = 4'b0000;
      step(10);
      check("buffered_pending", pending_dir, 4'b0010);
      check("buffered_cur", cur_dir, 4'b0001);
      valid_moves = 4'b0011;
      wait_strobe(12, seen, waited);
      check("turn_seen", {3'b000, seen}, 4'b0001);
      check("turn_dir", move_direction, 4'b0010);
      check("turn_cur", cur_dir, 4'b0010);

      // Blocked: stop, then stay stopped with no pending.
      valid_moves = 4'b1101;
      c = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (move_strobe) c++;
         if (cur_dir == 4'b0000) break;
      end
      check("blocked_strobes", 4'(c), 4'd0);
      check("blocked_cur", cur_dir, 4'b0000);
      valid_moves = 4'b1111;
      count_strobes(30, c);
      check("stopped_strobes", 4'(c), 4'd0);
      check("stopped_cur", cur_dir, 4'b0000);

      // Simultaneous press priority, then freeze with enable low.
      valid_moves = 4'b0000;
      btn_raw = 4'b0011;
      step(8);
      check("priority_pending", pending_dir, 4'b0001);
      enable = 1'b0;
      btn_raw = 4'b0000;
      count_strobes(20, c);
      check("frozen_strobes", 4'(c), 4'd0);
      check("frozen_pending", pending_dir, 4'b0001);
      enable = 1'b1;
      step(30);
`ifdef PENDING_TIMEOUT_EN
      check("timeout_pending", pending_dir, 4'b0000);
`else
      check("persist_pending", pending_dir, 4'b0001);
`endif

      // LEFT press with all moves legal, then a mid-operation reset.
      valid_moves = 4'b1111;
      btn_raw = 4'b1000;
      step(8);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (move_strobe && move_direction == 4'b1000) begin
            seen = 1'b1;
            break;
         end
      end
      check("left_seen", {3'b000, seen}, 4'b0001);
      check("left_cur", cur_dir, 4'b1000);
      rst = 1'b1;
      step(1);
      check("midreset_cur", cur_dir, 4'b0000);
      check("midreset_pending", pending_dir, 4'b0000);
      check("midreset_move", move_direction, 4'b0000);
      rst = 1'b0;
      btn_raw = 4'b0000;
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
